// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised inter-stage pipeline register with valid/ready handshake,
//   synchronous flush and a 1-entry skid buffer. Replaces the fixed-field
//   MEM/WB register; control fields travel packed inside the payload.
//   in_ready_o is decoded from state flops only, so there is no combinational
//   path from out_ready_i to in_ready_o, and 1 transfer/cycle is sustained
//   under back-pressure.
//
// Parameters
//   DATA_W   payload width in bits (>=1)
//   CNT_W    statistics counter width (only meaningful with stats enabled)
//
// Ports
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous reset, active low
//   flush_i       synchronous flush: drops held and incoming entries
//   in_valid_i    upstream payload valid
//   in_data_i     upstream payload
//   in_ready_o    stage can accept
//   out_valid_o   out_data_o holds a valid entry
//   out_data_o    payload to downstream
//   out_ready_i   downstream accepts
//   stall_cnt_o   [PIPE_STAGE_STATS_EN] cycles with out_valid_o & !out_ready_i
//   bubble_cnt_o  [PIPE_STAGE_STATS_EN] cycles with !out_valid_o
//
// Build option
//   PIPE_STAGE_STATS_EN  adds saturating stall/bubble counters and their ports.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // Outputs come straight from flops.
    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = (state_q != ST_SKID);
    assign out_data_o  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_valid_i) begin
                    main_d  = in_data_i;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_valid_i && out_ready_i) begin
                    main_d = in_data_i;               // pass-through, stay FULL
                end else if (!in_valid_i && out_ready_i) begin
                    state_d = ST_EMPTY;
                end else if (in_valid_i && !out_ready_i) begin
                    skid_d  = in_data_i;              // park the younger entry
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_ready_i) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins: only validity is dropped, data regs keep their contents.
        // An output handshake this cycle still completes from downstream's view.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; cleared by reset only, flush leaves them alone.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (!out_valid_o && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    // CNT_W only sizes the stats counters; keep the parameter referenced so
    // instantiations are identical with and without stats.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Scoreboard bench for pipe_stage_reg. Accepted inputs are pushed to a
//   queue; the queue head must be on out_data_o whenever out_valid_o is set
//   and is popped on each output handshake. Occupancy of the queue predicts
//   out_valid_o (size>0) and in_ready_o (size<2). With PIPE_STAGE_STATS_EN
//   the saturating counters are modelled too.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              flush_i;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  stall_m;
    logic [CNT_W-1:0]  bubble_m;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic r, input logic f);
        @(posedge clk_i);
        #1;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
    endtask

    // Monitor: samples on the falling edge, predicting the next rising edge.
    task automatic monitor();
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                sb_q.delete();
`ifdef PIPE_STAGE_STATS_EN
                stall_m  = '0;
                bubble_m = '0;
`endif
            end else begin
                chk("out_valid", 64'(out_valid_o), 64'(sb_q.size() > 0));
                chk("in_ready", 64'(in_ready_o), 64'(sb_q.size() < 2));
                if (out_valid_o && sb_q.size() > 0)
                    chk("out_data", 64'(out_data_o), 64'(sb_q[0]));
`ifdef PIPE_STAGE_STATS_EN
                chk("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
                chk("bubble_cnt", 64'(bubble_cnt_o), 64'(bubble_m));
                if (sb_q.size() > 0 && !out_ready_i && stall_m != {CNT_W{1'b1}})
                    stall_m = stall_m + 1'b1;
                if (sb_q.size() == 0 && bubble_m != {CNT_W{1'b1}})
                    bubble_m = bubble_m + 1'b1;
`endif
                if (out_valid_o && out_ready_i && sb_q.size() > 0)
                    void'(sb_q.pop_front());
                if (flush_i)
                    sb_q.delete();
                else if (in_valid_i && in_ready_o)
                    sb_q.push_back(in_data_i);
            end
        end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", 64'(out_data_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Streaming 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: A, B, then C offered while in SKID (must be ignored)
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while SKID holds A,B with C incoming
        step(1'b1, 32'h1A, 1'b0, 1'b0);
        step(1'b1, 32'h1B, 1'b0, 1'b0);
        step(1'b1, 32'h1C, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with an output handshake
        step(1'b1, 32'h2A, 1'b0, 1'b0);
        step(1'b1, 32'h2B, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous in/out while FULL
        step(1'b1, 32'h5A, 1'b0, 1'b0);
        step(1'b1, 32'h5B, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-transfer
        step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        step(1'b1, 32'hBEEF, 1'b0, 1'b0);
        @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_data", 64'(out_data_o), 64'd0);
        chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Hold one entry under back-pressure for 20 cycles
        step(1'b1, 32'h55, 1'b0, 1'b0);
        repeat (21) step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        chk("stall_hold_data", 64'(out_data_o), 64'h55);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_sat", 64'(stall_cnt_o), 64'd15);
`endif
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk_i);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
